// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with a fixed access latency.
// Optional build macro DMEM_ALIGN_CHECK_EN turns misaligned requests into error responses.
module data_mem_responder #(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] txn_count,
  output logic [1:0]  dbg_state_o
);

  localparam int          AW     = $clog2(MEM_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           misal_q, misal_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [15:0]    txn_q, txn_d;
  logic           mem_we;
  logic           req_misal;
  logic           unused_addr_bits;

  // Storage has no reset: contents survive reset by design.
  logic [31:0] mem_q [MEM_WORDS];

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_misal = (req_addr[1:0] != 2'b00);
`else
  assign req_misal = 1'b0;
`endif
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
  // a response on a rising edge with resp_valid && resp_ready; valid never waits on ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    misal_d = misal_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    txn_d   = txn_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          misal_d = req_misal;
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          mem_we  = wr_q && !misal_q;
          rdata_d = (wr_q || misal_q) ? 32'd0 : mem_q[idx_q];
          err_d   = misal_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          txn_d   = txn_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      misal_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      txn_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      misal_q <= misal_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign txn_count   = txn_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against an array-based memory model.
module tb_data_mem_responder;

  localparam int MEM_WORDS = 256;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_ready = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] txn_count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [MEM_WORDS];
  bit          written [MEM_WORDS];
  logic [15:0] exp_txn = 16'd0;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  // clock / reset
  always #5 clk = ~clk;

  data_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .txn_count  (txn_count),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: word-addressed memory, byte address taken modulo the memory size.
  function automatic void model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int idx;
    bit mis;
    idx = int'((addr >> 2) % MEM_WORDS);
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (addr % 4) != 0;
`endif
    if (mis) begin
      exp_q.push_back(32'd0);
      exp_err_q.push_back(1'b1);
    end else if (wr) begin
      ref_mem[idx] = wdata;
      written[idx] = 1'b1;
      exp_q.push_back(32'd0);
      exp_err_q.push_back(1'b0);
    end else begin
      exp_q.push_back(ref_mem[idx]);
      exp_err_q.push_back(1'b0);
    end
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_txn = 16'd0;
    #1;
  endtask

  // driver: one full transaction, optionally stalling the response and poking a request
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input bit poke);
    int n;
    logic [31:0] e_d;
    logic e_e;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    model(wr, addr, wdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, LATENCY);
    e_d = exp_q.pop_front();
    e_e = exp_err_q.pop_front();
    check("rdata", resp_rdata, e_d);
    check("err", {31'd0, resp_err}, {31'd0, e_e});
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = 32'hBAD0BAD0;
      end
      @(posedge clk); #1;
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, e_d);
      check("hold_err", {31'd0, resp_err}, {31'd0, e_e});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_txn", {16'd0, txn_count}, {16'd0, exp_txn});
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_txn++;
    check("post_valid", {31'd0, resp_valid}, 32'd0);
    check("txn_count", {16'd0, txn_count}, {16'd0, exp_txn});
  endtask

  initial begin
    int n;
    int cyc;
    logic [31:0] a;
    logic w;
    int idx;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_txn", {16'd0, txn_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // store then load
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0);

    // stalled response with an ignored request in the meantime
    do_txn(1'b0, 32'h10, 32'h0, 5, 1'b1);
    do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0);

    // address wrap-around
    do_txn(1'b1, 32'h400, 32'h11111111, 0, 1'b0);
    do_txn(1'b0, 32'h000, 32'h0, 0, 1'b0);

    // misaligned load
    do_txn(1'b0, 32'h13, 32'h0, 0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      idx = int'((a >> 2) % MEM_WORDS);
      w = $urandom_range(0, 1) == 1;
      if (!written[idx]) w = 1'b1;
      do_txn(w, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    // reset while a store is waiting: store must be discarded
    apply_reset();
    do_txn(1'b1, 32'h20, 32'h55, 0, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("wait_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("wait_rst_txn", {16'd0, txn_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_txn = 16'd0;
    #1;
    check("wait_rst_ready", {31'd0, req_ready}, 32'd1);
    do_txn(1'b0, 32'h20, 32'h0, 0, 1'b0);
    check("wait_rst_txn_one", {16'd0, txn_count}, 32'd1);

    // reset while a response is pending: not counted
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_rst_reached", {31'd0, resp_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("resp_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("resp_rst_rdata", resp_rdata, 32'd0);
    check("resp_rst_txn", {16'd0, txn_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_txn = 16'd0;

    // 65536 back-to-back handshakes
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h10;
    resp_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 65536 && cyc < 300000) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        if (n == 0) check("mem_kept_over_reset", resp_rdata, ref_mem[4]);
        if (n == 65535) check("txn_ffff", {16'd0, txn_count}, 32'h0000FFFF);
        n++;
      end
    end
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("wrap_handshakes", n, 65536);
    @(negedge clk);
    check("txn_wrap", {16'd0, txn_count}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
